// File: rtl/fetch_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_pkg
// Shared front-end definitions for the fetch PC generator:
//   - fetch_state_e   : sequencing states of the PC generator
//   - redirect_cause_e: which source decides the next PC in a given cycle
//   - group_bytes()   : bytes covered by one fetch group
//   - off_bits()      : number of PC bits addressing a byte inside a group
// -----------------------------------------------------------------------------
package fetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        S_START  = 2'd0,   // first cycle after reset release, nothing presented
        S_RUN    = 2'd1,   // a fetch group is presented
        S_BUBBLE = 2'd2    // one dead cycle following a flush/branch redirect
    } fetch_state_e;

    // Ordered by priority, highest first.
    typedef enum logic [2:0] {
        RC_NONE   = 3'd0,  // pc holds
        RC_FLUSH  = 3'd1,  // trap/exception redirect
        RC_BRANCH = 3'd2,  // resolved mispredict
        RC_PRED   = 3'd3,  // predictor-taken exit of the fired group
        RC_SEQ    = 3'd4   // sequential advance to the next aligned group
    } redirect_cause_e;

    function automatic int group_bytes(input int fetch_width);
        return fetch_width * 4;
    endfunction

    function automatic int off_bits(input int fetch_width);
        return $clog2(fetch_width * 4);
    endfunction

endpackage : fetch_pc_gen_pkg

// File: rtl/fetch_pc_gen_lane_mask.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_lane_mask
// Combinational per-lane valid mask for one fetch group.
// Lane i is valid when it is at or after the entry lane and, if the predictor
// marks a taken branch, at or before the lane holding that branch.
// A predicted slot below the entry lane yields an all-zero mask.
// Ports:
//   first_lane  in  SLOT_W       entry lane derived from the group PC
//   pred_taken  in  1            predictor reports a taken branch in the group
//   pred_slot   in  SLOT_W       lane holding the predicted branch
//   lane_mask   out FETCH_WIDTH  bit i = lane i valid
// -----------------------------------------------------------------------------
module fetch_pc_gen_lane_mask #(
    parameter int FETCH_WIDTH = 2,
    parameter int SLOT_W      = 1
) (
    input  logic [SLOT_W-1:0]      first_lane,
    input  logic                   pred_taken,
    input  logic [SLOT_W-1:0]      pred_slot,
    output logic [FETCH_WIDTH-1:0] lane_mask
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional logic, so no path leaves it unassigned and no latch is inferred.
        lane_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask[i] = (SLOT_W'(i) >= first_lane) &&
                           (!pred_taken || (SLOT_W'(i) <= pred_slot));
        end
    end

endmodule : fetch_pc_gen_lane_mask

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Fetch-group PC generator for a FETCH_WIDTH-wide front end. Arbitrates
// flush > branch > predicted-taken > sequential, presents the group over a
// valid/ready handshake and counts accepted flush/branch redirects.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               freezes handshake and PC advance (redirects still taken)
//   flush_valid/_addr   trap redirect (highest priority)
//   br_valid/_addr      mispredict redirect
//   pred_taken/_slot/_target  BTB prediction for the presented group
//   out_valid/out_ready handshake to the fetch buffer
//   out_pc              PC of the first valid lane
//   out_lane_mask       per-lane valid bits
//   redirect_cnt        saturating count of accepted flush/branch redirects
// -----------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              FETCH_WIDTH     = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
    parameter bit              REDIRECT_BUBBLE = 1'b1,
    parameter int              CNT_W           = 16,
    localparam int             SLOT_W          = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush_valid,
    input  logic [XLEN-1:0]        flush_addr,
    input  logic                   br_valid,
    input  logic [XLEN-1:0]        br_addr,
    input  logic                   pred_taken,
    input  logic [SLOT_W-1:0]      pred_slot,
    input  logic [XLEN-1:0]        pred_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [FETCH_WIDTH-1:0] out_lane_mask,
    output logic [CNT_W-1:0]       redirect_cnt
);

    localparam int GROUP_BYTES = group_bytes(FETCH_WIDTH);
    localparam int OFF_BITS    = off_bits(FETCH_WIDTH);

    fetch_state_e    state, state_next;
    redirect_cause_e cause;
    logic [XLEN-1:0] pc, pc_next, base;
    logic [SLOT_W-1:0] first_lane;
    logic            fire;
    logic            redirect;

    // Targets are word aligned; their two low bits are intentionally ignored.
    logic unused_low_bits;
    assign unused_low_bits = ^{flush_addr[1:0], br_addr[1:0], pred_target[1:0]};

    assign base = pc & ~XLEN'(GROUP_BYTES - 1);

    // With a single lane there is no lane-select field in the PC.
    if (FETCH_WIDTH > 1) begin : g_first_lane
        assign first_lane = pc[OFF_BITS-1:2];
    end else begin : g_first_lane_single
        assign first_lane = '0;
    end

    assign out_valid = (state == S_RUN);
    assign out_pc    = pc;
    assign fire      = out_valid & out_ready & ~stall;
    assign redirect  = flush_valid | br_valid;

    fetch_pc_gen_lane_mask #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .SLOT_W      (SLOT_W)
    ) u_lane_mask (
        .first_lane (first_lane),
        .pred_taken (pred_taken),
        .pred_slot  (pred_slot),
        .lane_mask  (out_lane_mask)
    );

    always_comb begin
        cause = RC_NONE;
        if (flush_valid)             cause = RC_FLUSH;
        else if (br_valid)           cause = RC_BRANCH;
        else if (fire && pred_taken) cause = RC_PRED;
        else if (fire)               cause = RC_SEQ;
    end

    always_comb begin
        pc_next    = pc;
        state_next = state;

        // START and BUBBLE each last exactly one cycle.
        if (state != S_RUN) state_next = S_RUN;

        unique case (cause)
            RC_FLUSH: begin
                pc_next    = {flush_addr[XLEN-1:2], 2'b00};
                state_next = REDIRECT_BUBBLE ? S_BUBBLE : S_RUN;
            end
            RC_BRANCH: begin
                pc_next    = {br_addr[XLEN-1:2], 2'b00};
                state_next = REDIRECT_BUBBLE ? S_BUBBLE : S_RUN;
            end
            RC_PRED:  pc_next = {pred_target[XLEN-1:2], 2'b00};
            RC_SEQ:   pc_next = base + XLEN'(GROUP_BYTES);   // wraps modulo 2^XLEN
            default:  pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
            pc    <= RESET_VECTOR;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples the pre-edge values, independent of order.
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Flush and branch in the same cycle are one redirect; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
        end else if (redirect && !(&redirect_cnt)) begin
            redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

endmodule : fetch_pc_gen

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
// Directed stimulus for fetch_pc_gen (FETCH_WIDTH=2). The main instance uses
// REDIRECT_BUBBLE=1, CNT_W=4; a second instance with REDIRECT_BUBBLE=0 shares
// the inputs and is inspected around the first branch redirect.
// Every fired group's expected PC/mask is queued by the stimulus and popped by
// a separate monitor at the falling edge when the handshake completes.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

    localparam int XLEN  = 32;
    localparam int FW    = 2;
    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            flush_valid;
    logic [XLEN-1:0] flush_addr;
    logic            br_valid;
    logic [XLEN-1:0] br_addr;
    logic            pred_taken;
    logic [0:0]      pred_slot;
    logic [XLEN-1:0] pred_target;
    logic            out_ready;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [FW-1:0]   out_lane_mask;
    logic [CNT_W-1:0] redirect_cnt;

    logic            nb_valid;
    logic [XLEN-1:0] nb_pc;
    logic [FW-1:0]   nb_mask;
    logic [15:0]     nb_cnt;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_pc_gen #(
        .XLEN(XLEN), .FETCH_WIDTH(FW), .RESET_VECTOR(32'h0),
        .REDIRECT_BUBBLE(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .flush_valid(flush_valid), .flush_addr(flush_addr),
        .br_valid(br_valid), .br_addr(br_addr),
        .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_lane_mask(out_lane_mask), .redirect_cnt(redirect_cnt)
    );

    fetch_pc_gen #(
        .XLEN(XLEN), .FETCH_WIDTH(FW), .RESET_VECTOR(32'h0),
        .REDIRECT_BUBBLE(1'b0), .CNT_W(16)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .flush_valid(flush_valid), .flush_addr(flush_addr),
        .br_valid(br_valid), .br_addr(br_addr),
        .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
        .out_valid(nb_valid), .out_ready(out_ready), .out_pc(nb_pc),
        .out_lane_mask(nb_mask), .redirect_cnt(nb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fire(input logic [31:0] pc, input logic [1:0] mask);
        exp_t e;
        e.pc   = pc;
        e.mask = mask;
        sb.push_back(e);
    endtask

    // Monitor: a group is consumed when valid, ready and not stalled.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !stall) begin
            if (sb.size() == 0) begin
                check("unexpected_fire_pc", out_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fire_pc", out_pc, e.pc);
                check("fire_mask", 32'(out_lane_mask), 32'(e.mask));
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; out_ready = 1'b1;
        flush_valid = 1'b0; flush_addr = '0;
        br_valid = 1'b0; br_addr = '0;
        pred_taken = 1'b0; pred_slot = '0; pred_target = '0;

        // Reset values
        repeat (3) cyc();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_mask", 32'(out_lane_mask), 32'h3);
        check("rst_cnt", 32'(redirect_cnt), 32'd0);

        // 1. START cycle, then sequential groups
        rst_n = 1'b1;
        check("start_valid", 32'(out_valid), 32'd0);
        expect_fire(32'h0, 2'b11);
        cyc();
        check("run_valid", 32'(out_valid), 32'd1);
        check("run_pc0", out_pc, 32'h0);
        cyc();
        check("run_pc8", out_pc, 32'h8);
        out_ready = 1'b0;

        // 2. Backpressure then stall: group at 0x8 must hold
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hold_ready_pc", out_pc, 32'h8);
            check("hold_ready_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("hold_stall_pc", out_pc, 32'h8);
        end
        expect_fire(32'h8, 2'b11);
        stall = 1'b0;
        cyc();
        check("adv_pc10", out_pc, 32'h10);

        // 5. Predicted-taken exit at lane 0
        out_ready   = 1'b0;
        pred_taken  = 1'b1;
        pred_slot   = 1'b0;
        pred_target = 32'h40;
        #1;
        check("pred_mask", 32'(out_lane_mask), 32'h1);
        cyc();
        check("pred_hold_pc", out_pc, 32'h10);
        expect_fire(32'h10, 2'b01);
        out_ready = 1'b1;
        cyc();
        check("pred_target_pc", out_pc, 32'h40);
        out_ready  = 1'b0;
        pred_taken = 1'b0;

        // 3. Branch redirect to an unaligned target, with and without bubble
        br_valid = 1'b1;
        br_addr  = 32'h106;
        cyc();
        br_valid = 1'b0;
        check("br_bubble_valid", 32'(out_valid), 32'd0);
        check("br_cnt", 32'(redirect_cnt), 32'd1);
        check("nb_valid", 32'(nb_valid), 32'd1);
        check("nb_pc", nb_pc, 32'h104);
        check("nb_mask", 32'(nb_mask), 32'h2);
        cyc();
        check("br_valid", 32'(out_valid), 32'd1);
        check("br_pc", out_pc, 32'h104);
        check("br_mask", 32'(out_lane_mask), 32'h2);
        // Illegal pred_slot below the entry lane: empty mask, still valid
        pred_taken = 1'b1;
        pred_slot  = 1'b0;
        #1;
        check("illegal_mask", 32'(out_lane_mask), 32'h0);
        check("illegal_valid", 32'(out_valid), 32'd1);
        pred_taken = 1'b0;
        #1;
        expect_fire(32'h104, 2'b10);
        out_ready = 1'b1;
        cyc();
        check("br_next_pc", out_pc, 32'h108);
        check("br_next_mask", 32'(out_lane_mask), 32'h3);
        out_ready = 1'b0;

        // 4. Flush and branch together under stall: flush wins, counted once
        stall       = 1'b1;
        flush_valid = 1'b1;
        flush_addr  = 32'h200;
        br_valid    = 1'b1;
        br_addr     = 32'h300;
        cyc();
        flush_valid = 1'b0;
        br_valid    = 1'b0;
        check("dual_cnt", 32'(redirect_cnt), 32'd2);
        check("dual_bubble", 32'(out_valid), 32'd0);
        cyc();
        check("dual_pc", out_pc, 32'h200);
        stall = 1'b0;

        // Sequential advance wraps at the top of the address space
        flush_valid = 1'b1;
        flush_addr  = 32'hFFFF_FFFE;
        cyc();
        flush_valid = 1'b0;
        check("wrap_cnt", 32'(redirect_cnt), 32'd3);
        cyc();
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_mask", 32'(out_lane_mask), 32'h2);
        expect_fire(32'hFFFF_FFFC, 2'b10);
        out_ready = 1'b1;
        cyc();
        check("wrap_next_pc", out_pc, 32'h0);
        out_ready = 1'b0;

        // 6. Saturation of the 4-bit counter
        br_valid = 1'b1;
        br_addr  = 32'h1000;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k == 12) check("sat_reach", 32'(redirect_cnt), 32'hF);
        end
        br_valid = 1'b0;
        check("sat_hold", 32'(redirect_cnt), 32'hF);
        cyc();
        cyc();
        check("sat_pc", out_pc, 32'h1000);
        check("sat_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_mask", 32'(out_lane_mask), 32'h3);
        check("arst_cnt", 32'(redirect_cnt), 32'd0);

        cyc();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_pc_gen
